// File: rtl/rv_regfile_pkg.sv
// Shared definitions for the rv_regfile register file.
// Contains:
//   - rf_state_e : clear sequencer states
//   - legal parameter ranges, checked at elaboration
//   - calc_aw    : index width, equal to max(1, clog2(n))
package rv_regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 64;
  localparam int NREGS_MIN  = 2;
  localparam int NREGS_MAX  = 64;
  localparam int NRD_MIN    = 1;
  localparam int NRD_MAX    = 4;

  function automatic int calc_aw(input int n);
    int a;
    a = $clog2(n);
    return (a < 1) ? 1 : a;
  endfunction

endpackage

// File: rtl/rv_regfile_if.sv
// Bus bundle for rv_regfile.
//   clr_req : request a full zero-clear (single-cycle pulse)
//   wen     : write enable
//   waddr   : write index
//   wdata   : write data
//   raddr   : packed read indices, port p at [p*AW +: AW]
//   rdata   : packed read data, port p at [p*DATA_W +: DATA_W]
//   busy    : clear sequence in progress
//   wr_drop : one-cycle pulse, a requested write was discarded
// The master modport belongs to the requester; the slave modport belongs to
// the register file.
interface rv_regfile_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2
);
  logic                  clr_req;
  logic                  wen;
  logic [AW-1:0]         waddr;
  logic [DATA_W-1:0]     wdata;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  busy;
  logic                  wr_drop;

  modport master (
    output clr_req, wen, waddr, wdata, raddr,
    input  rdata, busy, wr_drop
  );

  modport slave (
    input  clr_req, wen, waddr, wdata, raddr,
    output rdata, busy, wr_drop
  );
endinterface

// File: rtl/rv_regfile_clr.sv
// Clear sequencer for rv_regfile.
// Steps an index through 0..NREGS-1, one register per cycle, while busy.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset (reset -> CLEAR, idx 0)
//   i_clr_req   : restart the clear from index 0 (from READY or mid-clear)
//   o_clr_idx   : register being zeroed this cycle
//   o_busy      : 1 while in CLEAR
module rv_regfile_clr
  import rv_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_clr_req,
  output logic [AW-1:0] o_clr_idx,
  output logic          o_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_busy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_busy = 1'b1;
        if (i_clr_req) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_READY: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign o_clr_idx = r_idx;

endmodule

// File: rtl/rv_regfile.sv
// Multi-port register file with a sequenced zero-clear.
// Parameters: DATA_W word width, NREGS register count, NRD read ports,
//   SYNC_RD (1 = registered read), BYPASS (1 = forward same-cycle write),
//   ZERO_R0 (1 = register 0 reads as zero and ignores writes).
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   bus         : rv_regfile_if slave (clear request, write port, read ports,
//                 busy, wr_drop)
// The storage array has no reset; it is zeroed by the clear sequence, which
// reset starts.
module rv_regfile
  import rv_regfile_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int SYNC_RD = 0,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input logic        clk,
  input logic        arst_n,
  rv_regfile_if.slave bus
);

  localparam int            AW       = calc_aw(NREGS);
  localparam bit            FULL_MAP = (NREGS == (1 << AW));
  localparam logic [AW:0]   NREGS_W  = NREGS[AW:0];

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("rv_regfile: DATA_W out of range");
  end
  if (NREGS < NREGS_MIN || NREGS > NREGS_MAX) begin : g_bad_nregs
    $error("rv_regfile: NREGS out of range");
  end
  if (NRD < NRD_MIN || NRD > NRD_MAX) begin : g_bad_nrd
    $error("rv_regfile: NRD out of range");
  end
  if ((SYNC_RD != 0 && SYNC_RD != 1) || (BYPASS != 0 && BYPASS != 1) ||
      (ZERO_R0 != 0 && ZERO_R0 != 1)) begin : g_bad_flag
    $error("rv_regfile: SYNC_RD, BYPASS and ZERO_R0 must be 0 or 1");
  end

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [AW-1:0]     w_clr_idx;
  logic              w_busy;
  logic              w_waddr_in;
  logic              w_waddr_r0;
  logic              w_wr_accept;
  logic              r_wr_drop;

  rv_regfile_clr #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_clr_req (bus.clr_req),
    .o_clr_idx (w_clr_idx),
    .o_busy    (w_busy)
  );

  // Power-of-two sizes cover the whole index space, so no range compare.
  if (FULL_MAP) begin : g_wr_full
    assign w_waddr_in = 1'b1;
  end else begin : g_wr_part
    assign w_waddr_in = ({1'b0, bus.waddr} < NREGS_W);
  end

  assign w_waddr_r0  = (ZERO_R0 != 0) && (bus.waddr == '0);
  // A clear request wins over a write issued in the same cycle.
  assign w_wr_accept = bus.wen && !w_busy && !bus.clr_req && w_waddr_in && !w_waddr_r0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= bus.wen && !w_wr_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_accept) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     w_ra;
    logic              w_ra_in;
    logic              w_ra_ok;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;

    assign w_ra = bus.raddr[p*AW +: AW];

    if (FULL_MAP) begin : g_full
      assign w_ra_in = 1'b1;
    end else begin : g_part
      assign w_ra_in = ({1'b0, w_ra} < NREGS_W);
    end

    assign w_ra_ok = w_ra_in && !w_busy && !((ZERO_R0 != 0) && (w_ra == '0));
    assign w_hit   = (BYPASS != 0) && w_wr_accept && (bus.waddr == w_ra);

    always_comb begin
      w_data = '0;
      if (w_ra_ok) begin
        w_data = w_hit ? bus.wdata : r_mem[w_ra];
      end
    end

    if (SYNC_RD != 0) begin : g_sync
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          r_q <= '0;
        end else begin
          r_q <= w_data;
        end
      end
      assign bus.rdata[p*DATA_W +: DATA_W] = r_q;
    end else begin : g_comb
      assign bus.rdata[p*DATA_W +: DATA_W] = w_data;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.wr_drop = r_wr_drop;

endmodule

// File: tb/tb_rv_regfile.sv
// Bench for rv_regfile: three instances (default combinational/bypass;
// NREGS=24 without bypass; registered read) share clock and reset.
// Stimulus pushes expected values tagged with the cycle they are due; a
// monitor compares them on the falling edge of that cycle.
module tb_rv_regfile;

  localparam int DW  = 32;
  localparam int AWT = 5;

  localparam int unsigned DA = 0, DB = 1, DC = 2;
  localparam int unsigned RD0 = 0, RD1 = 1, BUSY = 2, DROP = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  rv_regfile_if #(.DATA_W(DW), .AW(AWT), .NRD(2)) ifa ();
  rv_regfile_if #(.DATA_W(DW), .AW(AWT), .NRD(2)) ifb ();
  rv_regfile_if #(.DATA_W(DW), .AW(AWT), .NRD(2)) ifc ();

  rv_regfile #(.DATA_W(DW), .NREGS(32), .NRD(2), .SYNC_RD(0), .BYPASS(1), .ZERO_R0(1))
    dut_a (.clk(clk), .arst_n(arst_n), .bus(ifa.slave));
  rv_regfile #(.DATA_W(DW), .NREGS(24), .NRD(2), .SYNC_RD(0), .BYPASS(0), .ZERO_R0(1))
    dut_b (.clk(clk), .arst_n(arst_n), .bus(ifb.slave));
  rv_regfile #(.DATA_W(DW), .NREGS(32), .NRD(2), .SYNC_RD(1), .BYPASS(1), .ZERO_R0(1))
    dut_c (.clk(clk), .arst_n(arst_n), .bus(ifc.slave));

  typedef struct {
    int unsigned cyc;
    int unsigned d;
    int unsigned sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int unsigned d, input int unsigned s);
    logic [63:0] rd;
    logic        b;
    logic        w;
    case (d)
      DA:      begin rd = ifa.rdata; b = ifa.busy; w = ifa.wr_drop; end
      DB:      begin rd = ifb.rdata; b = ifb.busy; w = ifb.wr_drop; end
      default: begin rd = ifc.rdata; b = ifc.busy; w = ifc.wr_drop; end
    endcase
    case (s)
      RD0:     return rd[31:0];
      RD1:     return rd[63:32];
      BUSY:    return {31'b0, b};
      default: return {31'b0, w};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act   = actual(sb[i].d, sb[i].sig);
        total = total + 1;
        if (act !== sb[i].val) begin
          bad = bad + 1;
          $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h",
                   sb[i].nm, sb[i].d, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int unsigned off, input int unsigned d, input int unsigned s,
                     input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.d   = d;
    e.sig = s;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic idle();
    ifa.clr_req = 1'b0; ifa.wen = 1'b0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
    ifb.clr_req = 1'b0; ifb.wen = 1'b0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    ifc.clr_req = 1'b0; ifc.wen = 1'b0; ifc.waddr = '0; ifc.wdata = '0; ifc.raddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drv(input int unsigned d, input bit we, input int unsigned wa,
                     input logic [31:0] wd, input int unsigned r0, input int unsigned r1,
                     input bit clr);
    logic [AWT-1:0] a5, p0, p1;
    a5 = AWT'(wa);
    p0 = AWT'(r0);
    p1 = AWT'(r1);
    case (d)
      DA: begin
        ifa.wen = we; ifa.waddr = a5; ifa.wdata = wd; ifa.raddr = {p1, p0}; ifa.clr_req = clr;
      end
      DB: begin
        ifb.wen = we; ifb.waddr = a5; ifb.wdata = wd; ifb.raddr = {p1, p0}; ifb.clr_req = clr;
      end
      default: begin
        ifc.wen = we; ifc.waddr = a5; ifc.wdata = wd; ifc.raddr = {p1, p0}; ifc.clr_req = clr;
      end
    endcase
  endtask

  initial begin
    int unsigned k;
    idle();
    arst_n = 1'b0;
    repeat (3) tick();

    // Reset state; a write attempt under reset must not raise wr_drop.
    drv(DA, 1, 5, 32'h1, 0, 0, 0);
    chk(0, DA, BUSY, 32'd1, "rst_busy");
    chk(0, DA, DROP, 32'd0, "rst_drop");
    chk(1, DA, DROP, 32'd0, "rst_drop_hold");
    chk(0, DC, RD0, 32'd0, "rst_sync_rd0");
    chk(0, DC, RD1, 32'd0, "rst_sync_rd1");

    // Release: busy for exactly NREGS cycles.
    tick();
    arst_n = 1'b1;
    chk(0,  DA, BUSY, 32'd1, "clr_busy_first");
    chk(31, DA, BUSY, 32'd1, "clr_busy_last");
    chk(32, DA, BUSY, 32'd0, "clr_done");
    chk(23, DB, BUSY, 32'd1, "clr24_busy_last");
    chk(24, DB, BUSY, 32'd0, "clr24_done");
    repeat (32) tick();

    for (int i = 0; i < 32; i++) begin
      tick();
      drv(DA, 0, 0, 0, i, 31 - i, 0);
      chk(0, DA, RD0, 32'd0, "post_clr_rd0");
      chk(0, DA, RD1, 32'd0, "post_clr_rd1");
    end

    // Combinational read with bypass.
    tick();
    drv(DA, 1, 5, 32'hDEADBEEF, 5, 6, 0);
    chk(0, DA, RD0, 32'hDEADBEEF, "bypass_rd0");
    chk(0, DA, RD1, 32'd0, "bypass_other_port");
    chk(1, DA, DROP, 32'd0, "good_write_no_drop");
    tick();
    drv(DA, 0, 0, 0, 5, 5, 0);
    chk(0, DA, RD0, 32'hDEADBEEF, "stored_rd0");
    chk(0, DA, RD1, 32'hDEADBEEF, "stored_rd1_same_addr");

    // r0 is hardwired: write dropped, no forwarding.
    tick();
    drv(DA, 1, 0, 32'hFFFFFFFF, 0, 5, 0);
    chk(0, DA, RD0, 32'd0, "r0_no_bypass");
    chk(0, DA, RD1, 32'hDEADBEEF, "r0_other_port");
    chk(1, DA, DROP, 32'd1, "r0_drop");
    tick();
    drv(DA, 0, 0, 0, 0, 0, 0);
    chk(0, DA, RD0, 32'd0, "r0_read");
    chk(1, DA, DROP, 32'd0, "drop_is_pulse");

    // NREGS=24, no bypass.
    tick();
    drv(DB, 1, 5, 32'hDEADBEEF, 5, 5, 0);
    chk(0, DB, RD0, 32'd0, "nobyp_old_rd0");
    chk(0, DB, RD1, 32'd0, "nobyp_old_rd1");
    tick();
    drv(DB, 0, 0, 0, 5, 0, 0);
    chk(0, DB, RD0, 32'hDEADBEEF, "nobyp_stored");
    tick();
    drv(DB, 1, 30, 32'h30303030, 30, 0, 0);
    chk(0, DB, RD0, 32'd0, "oor30_rd");
    chk(1, DB, DROP, 32'd1, "oor30_drop");
    tick();
    drv(DB, 1, 23, 32'h23232323, 30, 23, 0);
    chk(0, DB, RD0, 32'd0, "oor30_rd_again");
    chk(0, DB, RD1, 32'd0, "r23_old");
    chk(1, DB, DROP, 32'd0, "r23_no_drop");
    tick();
    drv(DB, 0, 0, 0, 23, 24, 0);
    chk(0, DB, RD0, 32'h23232323, "r23_stored");
    chk(0, DB, RD1, 32'd0, "r24_oor_rd");
    tick();
    drv(DB, 1, 24, 32'h24242424, 0, 0, 0);
    chk(1, DB, DROP, 32'd1, "r24_drop");

    // Registered read.
    tick();
    drv(DC, 1, 7, 32'h12345678, 0, 0, 0);
    chk(1, DC, RD0, 32'd0, "sync_r0_rd0");
    chk(1, DC, RD1, 32'd0, "sync_r0_rd1");
    tick();
    drv(DC, 0, 0, 0, 7, 7, 0);
    chk(1, DC, RD0, 32'h12345678, "sync_r7_rd0");
    chk(1, DC, RD1, 32'h12345678, "sync_r7_rd1");
    tick();
    drv(DC, 1, 9, 32'hA5A5A5A5, 9, 7, 0);
    chk(1, DC, RD0, 32'hA5A5A5A5, "sync_bypass");
    chk(1, DC, RD1, 32'h12345678, "sync_r7_again");
    tick();
    drv(DC, 0, 0, 0, 9, 0, 0);
    chk(1, DC, RD0, 32'hA5A5A5A5, "sync_r9_stored");
    chk(1, DC, RD1, 32'd0, "sync_r0_again");

    // Fill r1..r31, then clear on request.
    for (int i = 1; i < 32; i++) begin
      tick();
      drv(DA, 1, i, i, 0, 0, 0);
    end
    tick();
    drv(DA, 0, 0, 0, 1, 31, 0);
    chk(0, DA, RD0, 32'd1, "fill_r1");
    chk(0, DA, RD1, 32'd31, "fill_r31");
    tick();
    drv(DA, 0, 0, 0, 17, 17, 0);
    chk(0, DA, RD0, 32'd17, "fill_r17_p0");
    chk(0, DA, RD1, 32'd17, "fill_r17_p1");
    tick();
    k = cyc;
    drv(DA, 1, 9, 32'h99, 3, 0, 1);
    chk(0, DA, RD0, 32'd3, "clrreq_cycle_rd");
    chk(0, DA, BUSY, 32'd0, "clrreq_cycle_busy");
    chk(1, DA, BUSY, 32'd1, "clrreq_busy");
    chk(1, DA, DROP, 32'd1, "clrreq_write_drop");
    tick();
    drv(DA, 0, 0, 0, 3, 0, 0);
    chk(0, DA, RD0, 32'd0, "busy_rd_zero");
    tick();
    drv(DA, 1, 3, 32'h33, 3, 0, 0);
    chk(0, DA, RD0, 32'd0, "busy_write_no_bypass");
    chk(1, DA, DROP, 32'd1, "busy_write_drop");
    repeat (8) tick();
    if (cyc != k + 10) begin
      bad = bad + 1;
      $display("FAIL cycle_align got=%0d exp=%0d", cyc, k + 10);
    end
    // Second request mid-clear restarts from index 0.
    drv(DA, 0, 0, 0, 0, 0, 1);
    chk(32, DA, BUSY, 32'd1, "restart_busy_last");
    chk(33, DA, BUSY, 32'd0, "restart_done");
    repeat (32) tick();
    for (int i = 0; i < 32; i++) begin
      tick();
      drv(DA, 0, 0, 0, i, 31 - i, 0);
      chk(0, DA, RD0, 32'd0, "reclr_rd0");
      chk(0, DA, RD1, 32'd0, "reclr_rd1");
    end

    // Reset asserted at clr_idx=10.
    tick();
    drv(DA, 0, 0, 0, 0, 0, 1);
    repeat (11) tick();
    arst_n = 1'b0;
    chk(0, DA, BUSY, 32'd1, "midrst_busy");
    tick();
    chk(0, DA, BUSY, 32'd1, "midrst_busy_hold");
    chk(0, DC, RD0, 32'd0, "midrst_sync_rd");
    tick();
    arst_n = 1'b1;
    chk(0,  DA, BUSY, 32'd1, "midrst_rel_busy");
    chk(31, DA, BUSY, 32'd1, "midrst_busy_last");
    chk(32, DA, BUSY, 32'd0, "midrst_done");
    repeat (32) tick();
    tick();
    drv(DA, 0, 0, 0, 17, 31, 0);
    drv(DC, 0, 0, 0, 7, 9, 0);
    chk(0, DA, RD0, 32'd0, "midrst_r17");
    chk(0, DA, RD1, 32'd0, "midrst_r31");
    chk(1, DC, RD0, 32'd0, "midrst_c_r7");
    chk(1, DC, RD1, 32'd0, "midrst_c_r9");

    repeat (3) tick();
    foreach (sb[i]) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s never_checked due=%0d now=%0d", sb[i].nm, sb[i].cyc, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
